// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared MMIO map, timer CTRL bit layout and decode select type.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

   localparam logic [31:0] MMIO_BASE       = 32'h8000_0000;

   localparam logic [2:0]  GPIO_OUT_OFS    = 3'd0;
   localparam logic [2:0]  TIMER_COUNT_OFS = 3'd1;
   localparam logic [2:0]  TIMER_CMP_OFS   = 3'd2;
   localparam logic [2:0]  TIMER_CTRL_OFS  = 3'd3;
   localparam logic [2:0]  TIMER_PRESC_OFS = 3'd4;

   localparam int          CTRL_EN_BIT     = 0;
   localparam int          CTRL_AUTO_BIT   = 1;
   localparam int          CTRL_PEND_BIT   = 2;

   typedef enum logic [1:0] {
      SEL_RAM  = 2'd0,
      SEL_MMIO = 2'd1,
      SEL_NONE = 2'd2
   } mmio_sel_enum;

   function automatic logic [31:0] ctrl_word(input logic en,
                                             input logic auto_rl,
                                             input logic pend);
      logic [31:0] w;
      w                = '0;
      w[CTRL_EN_BIT]   = en;
      w[CTRL_AUTO_BIT] = auto_rl;
      w[CTRL_PEND_BIT] = pend;
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// Module   : mmio_timer
// Purpose  : Compare/interrupt timer (COUNT, CMP, CTRL); optional prescaler
//            when DMEM_MMIO_PRESCALE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_timer
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_count_i,
   input  logic        wr_cmp_i,
   input  logic        wr_ctrl_i,
`ifdef DMEM_MMIO_PRESCALE_EN
   input  logic        wr_presc_i,
`endif
   input  logic [31:0] wdata_i,
   input  logic [2:0]  rofs_i,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   logic [31:0] count_q, count_d;
   logic [31:0] cmp_q, cmp_d;
   logic        en_q, en_d;
   logic        auto_q, auto_d;
   logic        pend_q, pend_d;
   logic        w_tick;
   logic        w_match;

`ifdef DMEM_MMIO_PRESCALE_EN
   logic [15:0] presc_q, presc_d;
   logic [15:0] pcnt_q, pcnt_d;

   always_comb begin
      presc_d = wr_presc_i ? wdata_i[15:0] : presc_q;
      pcnt_d  = pcnt_q;
      w_tick  = 1'b0;
      if (en_q) begin
         if (pcnt_q == presc_q) begin
            pcnt_d = '0;
            w_tick = 1'b1;
         end else begin
            pcnt_d = pcnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         pcnt_q  <= '0;
      end else begin
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
      end
   end
`else
   assign w_tick = en_q;
`endif

   // Hardware update first, then software writes override; PEND set beats W1C.
   always_comb begin
      w_match = w_tick && (count_q == cmp_q);
      count_d = count_q;
      en_d    = en_q;
      auto_d  = auto_q;
      pend_d  = pend_q;
      if (w_tick) begin
         if (w_match) begin
            if (auto_q) count_d = '0;
            else        en_d    = 1'b0;
         end else begin
            count_d = count_q + 32'd1;
         end
      end
      if (wr_count_i) count_d = wdata_i;
      cmp_d = wr_cmp_i ? wdata_i : cmp_q;
      if (wr_ctrl_i) begin
         en_d   = wdata_i[CTRL_EN_BIT];
         auto_d = wdata_i[CTRL_AUTO_BIT];
         if (wdata_i[CTRL_PEND_BIT]) pend_d = 1'b0;
      end
      if (w_match) pend_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         cmp_q   <= 32'hFFFF_FFFF;
         en_q    <= 1'b0;
         auto_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         cmp_q   <= cmp_d;
         en_q    <= en_d;
         auto_q  <= auto_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (rofs_i)
         TIMER_COUNT_OFS: rdata_o = count_q;
         TIMER_CMP_OFS:   rdata_o = cmp_q;
         TIMER_CTRL_OFS:  rdata_o = ctrl_word(en_q, auto_q, pend_q);
`ifdef DMEM_MMIO_PRESCALE_EN
         TIMER_PRESC_OFS: rdata_o = {16'h0000, presc_q};
`endif
         default:         rdata_o = '0;
      endcase
   end

   assign irq_o = pend_q;

endmodule

`default_nettype wire

// File: rtl/dmem_mmio.sv
// ============================================================================
// Module   : dmem_mmio
// Purpose  : Data memory (comb read, sync write) plus GPIO/timer MMIO region.
//            Optional timer prescaler selected by DMEM_MMIO_PRESCALE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_mmio
   import riscv_pkg::*;
#(
   parameter int unsigned RAM_WORDS = 64,
   parameter int unsigned GPIO_W    = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [31:0]       a,
   input  logic [31:0]       wd,
   output logic [31:0]       rd,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              timer_irq
);

   localparam int unsigned c_AW        = $clog2(RAM_WORDS);
   localparam logic [29:0] c_RAM_LIMIT = 30'(RAM_WORDS);

   logic [31:0]       mem_q [0:RAM_WORDS-1];
   logic [GPIO_W-1:0] gpio_q;
   mmio_sel_enum      w_sel;
   logic [2:0]        w_ofs;
   logic              w_mmio_hit;
   logic              w_mmio_we;
   logic              w_ram_we;
   logic [c_AW-1:0]   w_ram_idx;
   logic [31:0]       w_timer_rdata;
   logic              w_unused_lsb;

   assign w_unused_lsb = ^a[1:0];
   assign w_ram_idx    = a[2 +: c_AW];

   always_comb begin
`ifdef DMEM_MMIO_PRESCALE_EN
      w_ofs      = a[4:2];
      w_mmio_hit = (a[31:5] == MMIO_BASE[31:5]) && (w_ofs <= TIMER_PRESC_OFS);
`else
      w_ofs      = {1'b0, a[3:2]};
      w_mmio_hit = (a[31:4] == MMIO_BASE[31:4]);
`endif
      w_sel = SEL_NONE;
      if (!a[31] && (a[31:2] < c_RAM_LIMIT)) w_sel = SEL_RAM;
      else if (w_mmio_hit)                   w_sel = SEL_MMIO;
   end

   assign w_ram_we  = we && (w_sel == SEL_RAM);
   assign w_mmio_we = we && (w_sel == SEL_MMIO);

   // RAM has no reset: contents survive a core reset.
   always_ff @(posedge clk) begin
      if (w_ram_we) mem_q[w_ram_idx] <= wd;
   end

   always_ff @(posedge clk) begin
      if (reset)                                   gpio_q <= '0;
      else if (w_mmio_we && w_ofs == GPIO_OUT_OFS) gpio_q <= wd[GPIO_W-1:0];
   end

   assign gpio_out = gpio_q;

   mmio_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .wr_count_i (w_mmio_we && (w_ofs == TIMER_COUNT_OFS)),
      .wr_cmp_i   (w_mmio_we && (w_ofs == TIMER_CMP_OFS)),
      .wr_ctrl_i  (w_mmio_we && (w_ofs == TIMER_CTRL_OFS)),
`ifdef DMEM_MMIO_PRESCALE_EN
      .wr_presc_i (w_mmio_we && (w_ofs == TIMER_PRESC_OFS)),
`endif
      .wdata_i    (wd),
      .rofs_i     (w_ofs),
      .rdata_o    (w_timer_rdata),
      .irq_o      (timer_irq)
   );

   always_comb begin
      rd = '0;
      case (w_sel)
         SEL_RAM:  rd = mem_q[w_ram_idx];
         SEL_MMIO: rd = (w_ofs == GPIO_OUT_OFS) ? 32'(gpio_q) : w_timer_rdata;
         default:  rd = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio.sv
// ============================================================================
// Module   : tb_dmem_mmio
// Purpose  : Self-checking bench for dmem_mmio against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_mmio;

   localparam logic [31:0] A_GPIO  = 32'h8000_0000;
   localparam logic [31:0] A_CNT   = 32'h8000_0004;
   localparam logic [31:0] A_CMP   = 32'h8000_0008;
   localparam logic [31:0] A_CTRL  = 32'h8000_000C;
   localparam logic [31:0] A_PRESC = 32'h8000_0010;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd;
   logic [7:0]  gpio_out;
   logic        timer_irq;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [31:0] m_mem [64];
   logic [7:0]  m_gpio;
   logic [31:0] m_count, m_cmp;
   bit          m_en, m_auto, m_pend;
   logic [15:0] m_presc, m_pcnt;

   dmem_mmio #(.RAM_WORDS(64), .GPIO_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .a         (a),
      .wd        (wd),
      .rd        (rd),
      .gpio_out  (gpio_out),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   function automatic bit model_is_mmio(input logic [31:0] ad);
`ifdef DMEM_MMIO_PRESCALE_EN
      return (ad >= 32'h8000_0000) && (ad < 32'h8000_0014);
`else
      return (ad >= 32'h8000_0000) && (ad < 32'h8000_0010);
`endif
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] ad);
      logic [31:0] ofs;
      if (ad < 32'h100) return m_mem[ad[7:2]];
      if (!model_is_mmio(ad)) return 32'h0;
      ofs = (ad - 32'h8000_0000) >> 2;
      case (ofs)
         32'd0:   return {24'h0, m_gpio};
         32'd1:   return m_count;
         32'd2:   return m_cmp;
         32'd3:   return {29'h0, m_pend, m_auto, m_en};
         32'd4:   return {16'h0, m_presc};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge();
      bit          tk, match;
      logic [31:0] ofs;
      if (we && a < 32'h100) m_mem[a[7:2]] = wd;
      if (reset) begin
         m_gpio = 8'h00; m_count = 32'h0; m_cmp = 32'hFFFF_FFFF;
         m_en = 0; m_auto = 0; m_pend = 0; m_presc = 16'h0; m_pcnt = 16'h0;
         return;
      end
      tk = 0;
      if (m_en) begin
`ifdef DMEM_MMIO_PRESCALE_EN
         if (m_pcnt == m_presc) begin tk = 1; m_pcnt = 16'h0; end
         else m_pcnt = m_pcnt + 16'h1;
`else
         tk = 1;
`endif
      end
      match = tk && (m_count == m_cmp);
      if (tk) begin
         if (match) begin
            m_pend = 1;
            if (m_auto) m_count = 32'h0; else m_en = 0;
         end else begin
            m_count = m_count + 32'h1;
         end
      end
      if (we && model_is_mmio(a)) begin
         ofs = (a - 32'h8000_0000) >> 2;
         case (ofs)
            32'd0: m_gpio  = wd[7:0];
            32'd1: m_count = wd;
            32'd2: m_cmp   = wd;
            32'd3: begin
               m_en   = wd[0];
               m_auto = wd[1];
               if (wd[2] && !match) m_pend = 0;
            end
            32'd4: m_presc = wd[15:0];
            default: ;
         endcase
      end
   endtask

   task automatic drive(input logic w, input logic [31:0] ad, input logic [31:0] d);
      we = w; a = ad; wd = d;
      #2;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, A_CNT, 0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 32'h4000_0000, 0);
      n_checks++; if (rd !== 32'h0) $display("FAIL reset_unmapped_rd: got %h want %h", rd, 32'h0); else n_pass++;
      tick();
      tick();
      reset = 1'b0;
      drive(0, A_CNT, 0);
      n_checks++; if (gpio_out !== 8'h00) $display("FAIL reset_gpio: got %h want %h", gpio_out, 8'h00); else n_pass++;
      n_checks++; if (timer_irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", timer_irq); else n_pass++;
      n_checks++; if (rd !== 32'h0) $display("FAIL reset_count: got %h want %h", rd, 32'h0); else n_pass++;
      tick();
      drive(0, A_CMP, 0);
      n_checks++; if (rd !== 32'hFFFF_FFFF) $display("FAIL reset_cmp: got %h want %h", rd, 32'hFFFF_FFFF); else n_pass++;
      tick();
      drive(0, A_CTRL, 0);
      n_checks++; if (rd !== 32'h0) $display("FAIL reset_ctrl: got %h want %h", rd, 32'h0); else n_pass++;
      tick();
   endtask

   task automatic test_ram();
      logic [31:0] ad;
      for (int i = 0; i < 64; i++) begin
         drive(1, 32'(i) << 2, $urandom);
         tick();
      end
      drive(1, 32'h10, 32'hCAFE_F00D);
      tick();
      drive(1, 32'h10, 32'h1234_5678);
      n_checks++; if (rd !== 32'hCAFE_F00D) $display("FAIL ram_rd_during_wr: got %h want %h", rd, 32'hCAFE_F00D); else n_pass++;
      tick();
      drive(1, 32'h10, 32'hCAFE_F00D);
      tick();
      drive(0, 32'h13, 0);
      n_checks++; if (rd !== 32'hCAFE_F00D) $display("FAIL ram_unaligned: got %h want %h", rd, 32'hCAFE_F00D); else n_pass++;
      tick();
      drive(1, 32'h100, 32'hDEAD_BEEF);
      n_checks++; if (rd !== 32'h0) $display("FAIL ram_oob_rd: got %h want %h", rd, 32'h0); else n_pass++;
      tick();
      drive(0, 32'h0, 0);
      n_checks++; if (rd !== model_read(32'h0)) $display("FAIL ram_oob_no_alias: got %h want %h", rd, model_read(32'h0)); else n_pass++;
      tick();
      for (int i = 0; i < 8; i++) begin
         ad = 32'($urandom_range(0, 255));
         drive(0, ad, 0);
         n_checks++; if (rd !== model_read(ad)) $display("FAIL ram_rand_rd: addr %h got %h want %h", ad, rd, model_read(ad)); else n_pass++;
         tick();
      end
   endtask

   task automatic test_gpio();
      drive(1, A_GPIO, 32'h1A5);
      tick();
      drive(0, A_GPIO, 0);
      n_checks++; if (gpio_out !== 8'hA5) $display("FAIL gpio_out: got %h want %h", gpio_out, 8'hA5); else n_pass++;
      n_checks++; if (rd !== 32'h0000_00A5) $display("FAIL gpio_rd: got %h want %h", rd, 32'h0000_00A5); else n_pass++;
      reset = 1'b1;
      drive(1, A_GPIO, 32'h77);
      tick();
      reset = 1'b0;
      drive(0, A_GPIO, 0);
      n_checks++; if (gpio_out !== 8'h00) $display("FAIL gpio_reset: got %h want %h", gpio_out, 8'h00); else n_pass++;
      tick();
   endtask

   task automatic test_oneshot();
      do_reset();
      drive(1, A_CMP, 5);
      tick();
      drive(1, A_CTRL, 32'h1);
      tick();
      for (int i = 0; i <= 5; i++) begin
         drive(0, A_CNT, 0);
         n_checks++; if (rd !== 32'(i)) $display("FAIL oneshot_count[%0d]: got %h want %h", i, rd, 32'(i)); else n_pass++;
         tick();
      end
      drive(0, A_CTRL, 0);
      n_checks++; if (timer_irq !== 1'b1) $display("FAIL oneshot_irq: got %b want 1", timer_irq); else n_pass++;
      n_checks++; if (rd !== 32'h4) $display("FAIL oneshot_ctrl: got %h want %h", rd, 32'h4); else n_pass++;
      tick();
      drive(0, A_CNT, 0);
      n_checks++; if (rd !== 32'h5) $display("FAIL oneshot_hold: got %h want %h", rd, 32'h5); else n_pass++;
      tick();
      drive(1, A_CTRL, 32'h4);
      tick();
      drive(0, A_CTRL, 0);
      n_checks++; if (timer_irq !== 1'b0) $display("FAIL oneshot_w1c: got %b want 0", timer_irq); else n_pass++;
      tick();
   endtask

   task automatic test_autoreload();
      do_reset();
      drive(1, A_CMP, 3);
      tick();
      drive(1, A_CTRL, 32'h3);
      tick();
      for (int i = 0; i < 10; i++) begin
         if (i == 7) begin
            drive(1, A_CTRL, 32'h7);
            n_checks++; if (rd !== 32'h7) $display("FAIL auto_ctrl: got %h want %h", rd, 32'h7); else n_pass++;
         end else begin
            drive(0, A_CNT, 0);
            n_checks++; if (rd !== 32'(i % 4)) $display("FAIL auto_count[%0d]: got %h want %h", i, rd, 32'(i % 4)); else n_pass++;
         end
         n_checks++; if (timer_irq !== (i >= 4)) $display("FAIL auto_irq[%0d]: got %b want %b", i, timer_irq, (i >= 4)); else n_pass++;
         tick();
      end
      drive(1, A_CTRL, 32'h7);
      tick();
      drive(0, A_CNT, 0);
      n_checks++; if (timer_irq !== 1'b0) $display("FAIL auto_w1c: got %b want 0", timer_irq); else n_pass++;
      n_checks++; if (rd !== 32'h3) $display("FAIL auto_count_after: got %h want %h", rd, 32'h3); else n_pass++;
      tick();
   endtask

   task automatic test_collision();
      do_reset();
      drive(1, A_CTRL, 32'h1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, A_CNT, 0);
         tick();
      end
      drive(1, A_CNT, 32'd100);
      n_checks++; if (rd !== 32'd3) $display("FAIL coll_pre: got %h want %h", rd, 32'd3); else n_pass++;
      tick();
      drive(0, A_CNT, 0);
      n_checks++; if (rd !== 32'd100) $display("FAIL coll_sw_wins: got %h want %h", rd, 32'd100); else n_pass++;
      tick();
      do_reset();
      drive(0, A_CNT, 0);
      n_checks++; if (rd !== 32'h0) $display("FAIL coll_rst_count: got %h want %h", rd, 32'h0); else n_pass++;
      tick();
      drive(0, A_CTRL, 0);
      n_checks++; if (rd !== 32'h0) $display("FAIL coll_rst_ctrl: got %h want %h", rd, 32'h0); else n_pass++;
      tick();
      drive(0, A_CMP, 0);
      n_checks++; if (rd !== 32'hFFFF_FFFF) $display("FAIL coll_rst_cmp: got %h want %h", rd, 32'hFFFF_FFFF); else n_pass++;
      tick();
      drive(1, A_CMP, 2);
      tick();
      drive(1, A_CTRL, 32'h1);
      tick();
      drive(0, A_CNT, 0);
      tick();
      drive(0, A_CNT, 0);
      tick();
      drive(1, A_CTRL, 32'h0);
      tick();
      drive(0, A_CTRL, 0);
      n_checks++; if (timer_irq !== 1'b1) $display("FAIL coll_en0_irq: got %b want 1", timer_irq); else n_pass++;
      n_checks++; if (rd !== 32'h4) $display("FAIL coll_en0_ctrl: got %h want %h", rd, 32'h4); else n_pass++;
      tick();
      drive(0, A_CNT, 0);
      n_checks++; if (rd !== 32'h2) $display("FAIL coll_en0_count: got %h want %h", rd, 32'h2); else n_pass++;
      tick();
   endtask

   task automatic test_prescale();
      do_reset();
      drive(1, A_GPIO, 32'h3C);
      tick();
`ifdef DMEM_MMIO_PRESCALE_EN
      drive(1, A_PRESC, 2);
      tick();
      drive(1, A_CMP, 2);
      tick();
      drive(1, A_CTRL, 32'h1);
      tick();
      for (int k = 1; k <= 9; k++) begin
         drive(0, A_PRESC, 0);
         n_checks++; if (timer_irq !== 1'b0) $display("FAIL presc_early[%0d]: got %b want 0", k, timer_irq); else n_pass++;
         tick();
      end
      drive(0, A_PRESC, 0);
      n_checks++; if (timer_irq !== 1'b1) $display("FAIL presc_irq: got %b want 1", timer_irq); else n_pass++;
      n_checks++; if (rd !== 32'h2) $display("FAIL presc_rd: got %h want %h", rd, 32'h2); else n_pass++;
      tick();
`else
      drive(1, A_PRESC, 32'hFF);
      n_checks++; if (rd !== 32'h0) $display("FAIL presc_unmapped_rd: got %h want %h", rd, 32'h0); else n_pass++;
      tick();
      drive(0, A_GPIO, 0);
      n_checks++; if (rd !== 32'h3C) $display("FAIL presc_unmapped_side: got %h want %h", rd, 32'h3C); else n_pass++;
      tick();
`endif
   endtask

   task automatic test_random();
      logic [31:0] ad, d;
      logic        w;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 5))
            0, 1:    ad = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            2:       ad = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            3:       ad = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2);
            4:       ad = $urandom;
            default: ad = 32'h100 + (32'($urandom_range(0, 255)) << 2);
         endcase
         w = ($urandom_range(0, 9) < 4);
         d = $urandom;
         if (ad >= 32'h8000_0004 && ad < 32'h8000_000C) d = 32'($urandom_range(0, 12));
         reset = ($urandom_range(0, 63) == 0);
         drive(w, ad, d);
         n_checks++; if (rd !== model_read(ad)) $display("FAIL rand_rd: addr %h got %h want %h", ad, rd, model_read(ad)); else n_pass++;
         n_checks++; if (gpio_out !== m_gpio) $display("FAIL rand_gpio: got %h want %h", gpio_out, m_gpio); else n_pass++;
         n_checks++; if (timer_irq !== m_pend) $display("FAIL rand_irq: got %b want %b", timer_irq, m_pend); else n_pass++;
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_ram();
      test_gpio();
      test_oneshot();
      test_autoreload();
      test_collision();
      test_prescale();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
